ex2_stage_reg: RTL and testbench

//  ID2->EX2 pipeline register bank for pipe 2. Captures the packet that the pipe-2 ID output

---
 rtl/ex2_stage_reg_pkg.sv | 44 ++++
 rtl/ex2_stage_reg_if.sv | 29 ++
 rtl/ex2_stage_reg_skid_slot.sv | 50 +++++
 rtl/ex2_stage_reg.sv | 155 +++++++++++++++
 tb/tb_ex2_stage_reg.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex2_stage_reg_pkg.sv
// ex2_pkg: packet layout, occupancy encoding and helpers shared by the ID2->EX2 register bank.
// Field order of ex2_pkt_t is fixed; aluop occupies the MSBs of the packed vector.
package ex2_pkg;

  localparam int unsigned EX2_PKT_W = 162;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [1:0]  alusrc1;
    logic        alusrc2;
    logic [2:0]  branchop;
    logic        brnch_sel;
    logic [31:0] immed;
    logic [3:0]  memop;
    logic        order;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        regwrite;
    logic [1:0]  rfwt_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ex2_pkt_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } ex2_occ_e;

  function automatic logic [EX2_PKT_W-1:0] ex2_pack(input ex2_pkt_t p);
    return p;
  endfunction

  function automatic ex2_pkt_t ex2_unpack(input logic [EX2_PKT_W-1:0] v);
    return ex2_pkt_t'(v);
  endfunction

  function automatic ex2_occ_e ex2_occ_of(input logic m_vld, input logic s_vld);
    return ex2_occ_e'({1'b0, m_vld} + {1'b0, s_vld});
  endfunction

endpackage

// File: rtl/ex2_stage_reg_if.sv
// ID2->EX2 bank bus: master is the ID2/EX2 side driving packets and control, slave is the bank.
interface ex2_stage_reg_if
  import ex2_pkg::*;
#(
  parameter int unsigned PKT_W = EX2_PKT_W
);

  logic [PKT_W-1:0] ex2_pkt_d;
  logic             ex2_valid_d;
  logic             ex2_we;
  logic             id2_ready;
  logic             ex2_stall;
  logic             ex2_flush;
  logic [PKT_W-1:0] ex2_pkt_q;
  logic             ex2_valid_q;
  logic [1:0]       ex2_occ;
  logic             ex2_ovf_err;

  modport master (
    output ex2_pkt_d, ex2_valid_d, ex2_we, ex2_stall, ex2_flush,
    input  id2_ready, ex2_pkt_q, ex2_valid_q, ex2_occ, ex2_ovf_err
  );

  modport slave (
    input  ex2_pkt_d, ex2_valid_d, ex2_we, ex2_stall, ex2_flush,
    output id2_ready, ex2_pkt_q, ex2_valid_q, ex2_occ, ex2_ovf_err
  );

endinterface

// File: rtl/ex2_stage_reg_skid_slot.sv
// ex2_skid_slot: one valid bit plus payload with load/clear; used for both main and skid entries.
// Valid always resets; payload resets only when PAYLOAD_RST=1.
module ex2_skid_slot #(
  parameter int unsigned W           = 162,
  parameter bit          PAYLOAD_RST = 1'b1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_pkt,
  output logic         o_vld,
  output logic [W-1:0] o_pkt
);

  logic         r_vld;
  logic [W-1:0] r_pkt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld <= 1'b0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld <= 1'b1;
    end
  end

  generate
    if (PAYLOAD_RST) begin : g_pkt_rst
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_pkt <= '0;
        end else if (i_load) begin
          r_pkt <= i_pkt;
        end
      end
    end else begin : g_pkt_norst
      always_ff @(posedge CLK) begin
        if (i_load) begin
          r_pkt <= i_pkt;
        end
      end
    end
  endgenerate

  assign o_vld = r_vld;
  assign o_pkt = r_pkt;

endmodule

// File: rtl/ex2_stage_reg.sv
// ex2_stage_reg: ID2->EX2 pipeline register bank for pipe 2 with stall hold and flush-to-bubble.
// EX2_SKID_EN adds a skid entry so id2_ready is registered; without it ready is combinational.
module ex2_stage_reg
  import ex2_pkg::*;
#(
  parameter int unsigned PKT_W       = EX2_PKT_W,
  parameter bit          PAYLOAD_RST = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  ex2_stage_reg_if.slave  bus
);

  logic             w_m_vld;
  logic [PKT_W-1:0] w_m_pkt;
  logic [PKT_W-1:0] w_m_din;
  logic             w_m_load;
  logic             w_m_clr;
  logic             w_m_vld_nxt;
  logic             w_s_vld;
  logic             w_s_vld_nxt;
  logic             w_consume;
  logic             w_accept;
  logic             w_ready;
  logic             w_ovf_hit;
  ex2_occ_e         r_occ;
  logic             r_ovf;

  assign w_consume = w_m_vld & ~bus.ex2_stall;
  assign w_accept  = bus.ex2_we & bus.ex2_valid_d & w_ready;
  assign w_ovf_hit = bus.ex2_we & bus.ex2_valid_d & ~w_ready;

`ifdef EX2_SKID_EN
  logic             r_ready;
  logic             w_m_from_s;
  logic             w_s_load;
  logic             w_s_clr;
  logic [PKT_W-1:0] w_s_pkt;

  assign w_ready = r_ready;

  // Skid drains into main before anything new is taken, keeping strict FIFO order.
  always_comb begin
    w_m_load   = 1'b0;
    w_m_clr    = 1'b0;
    w_m_from_s = 1'b0;
    w_s_load   = 1'b0;
    w_s_clr    = 1'b0;
    if (bus.ex2_flush) begin
      w_m_clr = 1'b1;
      w_s_clr = 1'b1;
    end else if (w_s_vld && w_consume) begin
      w_m_load   = 1'b1;
      w_m_from_s = 1'b1;
      w_s_clr    = 1'b1;
    end else if (w_accept && (!w_m_vld || w_consume)) begin
      w_m_load = 1'b1;
    end else if (w_accept) begin
      w_s_load = 1'b1;
    end else if (w_consume) begin
      w_m_clr = 1'b1;
    end
  end

  assign w_m_din     = w_m_from_s ? w_s_pkt : bus.ex2_pkt_d;
  assign w_s_vld_nxt = w_s_load | (w_s_vld & ~w_s_clr);

  ex2_skid_slot #(
    .W           (PKT_W),
    .PAYLOAD_RST (PAYLOAD_RST)
  ) u_slot_s (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_load (w_s_load),
    .i_clr  (w_s_clr),
    .i_pkt  (bus.ex2_pkt_d),
    .o_vld  (w_s_vld),
    .o_pkt  (w_s_pkt)
  );
`else
  // Without a skid entry, ready must drop in the same cycle EX2 stalls a held packet.
  assign w_ready = ~(w_m_vld & bus.ex2_stall);

  always_comb begin
    w_m_load = 1'b0;
    w_m_clr  = 1'b0;
    if (bus.ex2_flush) begin
      w_m_clr = 1'b1;
    end else if (w_accept) begin
      w_m_load = 1'b1;
    end else if (w_consume) begin
      w_m_clr = 1'b1;
    end
  end

  assign w_m_din     = bus.ex2_pkt_d;
  assign w_s_vld     = 1'b0;
  assign w_s_vld_nxt = 1'b0;
`endif

  assign w_m_vld_nxt = w_m_load | (w_m_vld & ~w_m_clr);

  ex2_skid_slot #(
    .W           (PKT_W),
    .PAYLOAD_RST (PAYLOAD_RST)
  ) u_slot_m (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_load (w_m_load),
    .i_clr  (w_m_clr),
    .i_pkt  (w_m_din),
    .o_vld  (w_m_vld),
    .o_pkt  (w_m_pkt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_occ   <= OCC_EMPTY;
      r_ovf   <= 1'b0;
`ifdef EX2_SKID_EN
      r_ready <= 1'b1;
`endif
    end else begin
      r_occ <= ex2_occ_of(w_m_vld_nxt, w_s_vld_nxt);
      if (w_ovf_hit) begin
        r_ovf <= 1'b1;
      end
`ifdef EX2_SKID_EN
      r_ready <= ~w_s_vld_nxt;
`endif
    end
  end

  assign bus.ex2_pkt_q   = w_m_pkt;
  assign bus.ex2_valid_q = w_m_vld;
  assign bus.id2_ready   = w_ready;
  assign bus.ex2_ovf_err = r_ovf;
`ifdef EX2_SKID_EN
  assign bus.ex2_occ     = r_occ;
`else
  assign bus.ex2_occ     = {1'b0, r_occ == OCC_ONE};
`endif

  a_pkt_w: assert property (@(posedge CLK) PKT_W == EX2_PKT_W);

  a_skid_order: assert property (@(posedge CLK) disable iff (!RST_N)
    !(w_s_vld && !w_m_vld));

  a_occ_max: assert property (@(posedge CLK) disable iff (!RST_N)
    bus.ex2_occ <= 2'd2);

  a_occ_track: assert property (@(posedge CLK) disable iff (!RST_N)
    bus.ex2_occ == ({1'b0, w_m_vld} + {1'b0, w_s_vld}));

endmodule

// File: tb/tb_ex2_stage_reg.sv
// Bench for ex2_stage_reg: directed scenarios plus a random run against a FIFO scoreboard.
// Checks adapt to the EX2_SKID_EN build option.
module tb_ex2_stage_reg;
  import ex2_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  ex2_stage_reg_if #(.PKT_W(EX2_PKT_W)) bif ();

  ex2_stage_reg #(
    .PKT_W       (EX2_PKT_W),
    .PAYLOAD_RST (1'b1)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Scoreboard: packets accepted and not yet consumed, oldest first.
  ex2_pkt_t q[$];
  ex2_pkt_t cur_pkt;
  logic     m_rdy_r = 1'b1;
  logic     m_ovf   = 1'b0;

  function automatic ex2_pkt_t mk_pkt(input logic [31:0] pc);
    logic [191:0] r;
    ex2_pkt_t     p;
    r    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    p    = ex2_unpack(r[EX2_PKT_W-1:0]);
    p.pc = pc;
    return p;
  endfunction

  function automatic logic model_ready();
`ifdef EX2_SKID_EN
    return m_rdy_r;
`else
    return !((q.size() > 0) && bif.ex2_stall);
`endif
  endfunction

  function automatic logic [31:0] pc_q();
    ex2_pkt_t p;
    p = ex2_unpack(bif.ex2_pkt_q);
    return p.pc;
  endfunction

  task automatic set_in(input logic we, input logic vld, input logic [31:0] pc,
                        input logic stall, input logic flush);
    cur_pkt         = mk_pkt(pc);
    bif.ex2_we      = we;
    bif.ex2_valid_d = vld;
    bif.ex2_pkt_d   = ex2_pack(cur_pkt);
    bif.ex2_stall   = stall;
    bif.ex2_flush   = flush;
  endtask

  task automatic drive(input logic we, input logic vld, input logic [31:0] pc,
                       input logic stall, input logic flush);
    @(negedge clk);
    set_in(we, vld, pc, stall, flush);
    #1;
  endtask

  // Advance the scoreboard by the cycle currently driven, then cross the clock edge.
  task automatic commit();
    logic rdy, cons, acc;
    rdy  = model_ready();
    cons = (q.size() > 0) && !bif.ex2_stall;
    acc  = bif.ex2_we && bif.ex2_valid_d && rdy;
    if (bif.ex2_we && bif.ex2_valid_d && !rdy) m_ovf = 1'b1;
    if (bif.ex2_flush) begin
      q.delete();
      m_rdy_r = 1'b1;
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(cur_pkt);
      m_rdy_r = (q.size() < 2);
    end
    @(posedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy_r = 1'b1;
    m_ovf   = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (bif.ex2_valid_q !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_valid cyc%0d: got %b want 0", i, bif.ex2_valid_q);
      end
      vectors++;
      if (bif.id2_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_ready cyc%0d: got %b want 1", i, bif.id2_ready);
      end
      vectors++;
      if (bif.ex2_occ !== 2'd0 || bif.ex2_ovf_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_occ cyc%0d: got occ=%0d ovf=%b want 0/0", i, bif.ex2_occ, bif.ex2_ovf_err);
      end
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [4];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 1'b1, (i < 4) ? pcs[i] : 32'h0, 1'b0, 1'b0);
      vectors++;
      if (bif.id2_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready cyc%0d: got %b want 1", i, bif.id2_ready);
      end
      if (i >= 1 && i <= 3) begin
        vectors++;
        if (bif.ex2_valid_q !== 1'b1 || pc_q() !== pcs[i-1]) begin
          miscompares++;
          $display("FAIL stream_pc cyc%0d: got v=%b pc=%h want v=1 pc=%h", i, bif.ex2_valid_q, pc_q(), pcs[i-1]);
        end
        vectors++;
        if (bif.ex2_occ !== 2'd1) begin
          miscompares++;
          $display("FAIL stream_occ cyc%0d: got %0d want 1", i, bif.ex2_occ);
        end
      end
      if (i == 4) begin
        vectors++;
        if (bif.ex2_valid_q !== 1'b0 || bif.ex2_occ !== 2'd0) begin
          miscompares++;
          $display("FAIL stream_drain: got v=%b occ=%0d want 0/0", bif.ex2_valid_q, bif.ex2_occ);
        end
      end
      commit();
    end
  endtask

`ifdef EX2_SKID_EN
  task automatic test_stall_fill();
    drive(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
    commit();
    drive(1'b1, 1'b1, 32'h204, 1'b1, 1'b0);
    vectors++;
    if (bif.id2_ready !== 1'b1 || pc_q() !== 32'h200) begin
      miscompares++;
      $display("FAIL fill_first: got rdy=%b pc=%h want 1/200", bif.id2_ready, pc_q());
    end
    commit();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bif.ex2_occ !== 2'd2 || bif.id2_ready !== 1'b0 || pc_q() !== 32'h200) begin
      miscompares++;
      $display("FAIL fill_full: got occ=%0d rdy=%b pc=%h want 2/0/200", bif.ex2_occ, bif.id2_ready, pc_q());
    end
    commit();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (bif.ex2_valid_q !== 1'b1 || pc_q() !== 32'h204 || bif.id2_ready !== 1'b1 || bif.ex2_occ !== 2'd1) begin
      miscompares++;
      $display("FAIL fill_drain: got v=%b pc=%h rdy=%b occ=%0d want 1/204/1/1", bif.ex2_valid_q, pc_q(), bif.id2_ready, bif.ex2_occ);
    end
    commit();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    commit();
  endtask
`else
  task automatic test_no_skid();
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    commit();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      vectors++;
      if (bif.id2_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL noskid_ready cyc%0d: got %b want 0", i, bif.id2_ready);
      end
      vectors++;
      if (bif.ex2_occ !== 2'd1 || pc_q() !== 32'h200) begin
        miscompares++;
        $display("FAIL noskid_occ cyc%0d: got occ=%0d pc=%h want 1/200", i, bif.ex2_occ, pc_q());
      end
      commit();
    end
    drive(1'b1, 1'b1, 32'h204, 1'b0, 1'b0);
    vectors++;
    if (bif.id2_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL noskid_release: got %b want 1", bif.id2_ready);
    end
    commit();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (pc_q() !== 32'h204 || bif.ex2_occ !== 2'd1) begin
      miscompares++;
      $display("FAIL noskid_next: got pc=%h occ=%0d want 204/1", pc_q(), bif.ex2_occ);
    end
    commit();
  endtask
`endif

  task automatic test_flush();
    drive(1'b1, 1'b1, 32'h2F0, 1'b1, 1'b0);
    commit();
`ifdef EX2_SKID_EN
    drive(1'b1, 1'b1, 32'h2F4, 1'b1, 1'b0);
    commit();
`endif
    drive(1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
    commit();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++;
      if (bif.ex2_valid_q !== 1'b0 || bif.ex2_occ !== 2'd0) begin
        miscompares++;
        $display("FAIL flush_empty cyc%0d: got v=%b occ=%0d pc=%h want 0/0", i, bif.ex2_valid_q, bif.ex2_occ, pc_q());
      end
      vectors++;
      if (bif.id2_ready !== 1'b1 || bif.ex2_ovf_err !== m_ovf) begin
        miscompares++;
        $display("FAIL flush_ready cyc%0d: got rdy=%b ovf=%b want 1/%b", i, bif.id2_ready, bif.ex2_ovf_err, m_ovf);
      end
      commit();
    end
    drive(1'b1, 1'b1, 32'h304, 1'b0, 1'b1);
    commit();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bif.ex2_valid_q !== 1'b0 || bif.ex2_occ !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_drop: got v=%b occ=%0d want 0/0", bif.ex2_valid_q, bif.ex2_occ);
    end
    commit();
    reset_dut();
  endtask

  task automatic test_bubble_ovf();
    drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
    commit();
    drive(1'b1, 1'b0, 32'h0DEAD, 1'b1, 1'b0);
    commit();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (bif.ex2_occ !== 2'd1 || pc_q() !== 32'h400 || bif.ex2_ovf_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble: got occ=%0d pc=%h ovf=%b want 1/400/0", bif.ex2_occ, pc_q(), bif.ex2_ovf_err);
    end
    commit();
`ifdef EX2_SKID_EN
    drive(1'b1, 1'b1, 32'h404, 1'b1, 1'b0);
    commit();
`endif
    drive(1'b1, 1'b1, 32'h408, 1'b1, 1'b0);
    vectors++;
    if (bif.id2_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_ready: got %b want 0", bif.id2_ready);
    end
    commit();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++;
      if (bif.ex2_ovf_err !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_sticky cyc%0d: got %b want 1", i, bif.ex2_ovf_err);
      end
      vectors++;
      if (bif.ex2_valid_q === 1'b1 && pc_q() === 32'h408) begin
        miscompares++;
        $display("FAIL ovf_dropped cyc%0d: got pc=%h want not 408", i, pc_q());
      end
      commit();
    end
    reset_dut();
    #1;
    vectors++;
    if (bif.ex2_ovf_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b want 0", bif.ex2_ovf_err);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 32'h4F0, 1'b1, 1'b0);
    commit();
    drive(1'b1, 1'b1, 32'h4F4, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bif.ex2_valid_q !== 1'b0 || bif.ex2_occ !== 2'd0 || bif.id2_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_rst: got v=%b occ=%0d rdy=%b want 0/0/1", bif.ex2_valid_q, bif.ex2_occ, bif.id2_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
    #1;
    commit();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bif.ex2_valid_q !== 1'b1 || pc_q() !== 32'h500) begin
      miscompares++;
      $display("FAIL first_accept: got v=%b pc=%h want 1/500", bif.ex2_valid_q, pc_q());
    end
    commit();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, pc,
            $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0);
      pc = pc + 32'd4;
      vectors++;
      if (bif.ex2_valid_q !== (q.size() > 0)) begin
        miscompares++;
        $display("FAIL b2b_valid cyc%0d: got %b want %b", i, bif.ex2_valid_q, q.size() > 0);
      end
      if (q.size() > 0) begin
        vectors++;
        if (bif.ex2_pkt_q !== q[0]) begin
          miscompares++;
          $display("FAIL b2b_pkt cyc%0d: got %h want %h", i, bif.ex2_pkt_q, q[0]);
        end
      end
      vectors++;
      if (bif.ex2_occ !== 2'(q.size())) begin
        miscompares++;
        $display("FAIL b2b_occ cyc%0d: got %0d want %0d", i, bif.ex2_occ, q.size());
      end
      vectors++;
      if (bif.id2_ready !== model_ready()) begin
        miscompares++;
        $display("FAIL b2b_ready cyc%0d: got %b want %b", i, bif.id2_ready, model_ready());
      end
      vectors++;
      if (bif.ex2_ovf_err !== m_ovf) begin
        miscompares++;
        $display("FAIL b2b_ovf cyc%0d: got %b want %b", i, bif.ex2_ovf_err, m_ovf);
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
`ifdef EX2_SKID_EN
    test_stall_fill();
`else
    test_no_skid();
`endif
    test_flush();
    test_bubble_ovf();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
